// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU_16bit sequencer: FSM state encoding,
// slice width and the 74181-style function-select codes used by the front end.
package alu_seq_pkg;

    localparam int unsigned ALU_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } seq_state_t;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;
    // Same code as S_SUB; selects XOR only when M = 1.
    localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/alu16_seq_driver_if.sv
// Command/response streams and ALU_16bit pins of the sequencer.
// rsp_zero/rsp_neg exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu16_seq_driver_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = ALU_W
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2*W-1:0] cmd_a;
    logic [2*W-1:0] cmd_b;
    logic [3:0]     cmd_s;
    logic           cmd_m;
    logic           cmd_cin_n;
    logic           cmd_wide;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_f;
    logic           rsp_carry;
`ifdef ALU_SEQ_FLAGS_EN
    logic           rsp_zero;
    logic           rsp_neg;
`endif

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [3:0]     alu_s;
    logic           alu_m;
    logic           alu_cin_n;
    logic [W-1:0]   alu_f;
    logic           alu_cout_n;

`ifdef ALU_SEQ_FLAGS_EN
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin_n, cmd_wide,
        output cmd_ready,
        output rsp_valid, rsp_f, rsp_carry, rsp_zero, rsp_neg,
        input  rsp_ready,
        output alu_a, alu_b, alu_s, alu_m, alu_cin_n,
        input  alu_f, alu_cout_n
    );
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin_n, cmd_wide,
        input  cmd_ready,
        input  rsp_valid, rsp_f, rsp_carry, rsp_zero, rsp_neg,
        output rsp_ready,
        input  alu_a, alu_b, alu_s, alu_m, alu_cin_n,
        output alu_f, alu_cout_n
    );
`else
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin_n, cmd_wide,
        output cmd_ready,
        output rsp_valid, rsp_f, rsp_carry,
        input  rsp_ready,
        output alu_a, alu_b, alu_s, alu_m, alu_cin_n,
        input  alu_f, alu_cout_n
    );
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin_n, cmd_wide,
        input  cmd_ready,
        input  rsp_valid, rsp_f, rsp_carry,
        output rsp_ready,
        input  alu_a, alu_b, alu_s, alu_m, alu_cin_n,
        output alu_f, alu_cout_n
    );
`endif

endinterface

// File: rtl/alu_seq_latch.sv
// Registered copy of the accepted command; selects the low or high operand
// half presented to the ALU A/B pins.
module alu_seq_latch
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = ALU_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           go_hi,
    input  logic [2*W-1:0] a_in,
    input  logic [2*W-1:0] b_in,
    input  logic [3:0]     s_in,
    input  logic           m_in,
    input  logic           wide_in,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [3:0]     s,
    output logic           m,
    output logic           wide
);
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;
    logic           hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            s    <= '0;
            m    <= 1'b0;
            wide <= 1'b0;
            hi_q <= 1'b0;
        end else if (load) begin
            a_q  <= a_in;
            b_q  <= b_in;
            s    <= s_in;
            m    <= m_in;
            wide <= wide_in;
            hi_q <= 1'b0;
        end else if (go_hi) begin
            hi_q <= 1'b1;
        end
    end

    assign alu_a = hi_q ? a_q[2*W-1:W] : a_q[W-1:0];
    assign alu_b = hi_q ? b_q[2*W-1:W] : b_q[W-1:0];

endmodule

// File: rtl/alu16_seq_driver.sv
// Sequences narrow (W-bit) and wide (2W-bit, carry-chained) ops through an
// external ALU_16bit. Defining ALU_SEQ_FLAGS_EN adds registered zero/neg flags.
module alu16_seq_driver
    import alu_seq_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned W       = ALU_W
) (
    input logic               clk,
    input logic               rst,
    alu16_seq_driver_if.slave bus
);
    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

    seq_state_t     state;
    logic [2:0]     lat_cnt;
    logic [2*W-1:0] res;
    logic           c_n;
    logic           cmd_ready;
    logic           rsp_valid;
    logic [2*W-1:0] rsp_f;
    logic           rsp_carry;
    logic           alu_cin_n;
    logic           load;
    logic           go_hi;
    logic [3:0]     s_q;
    logic           m_q;
    logic           wide_q;
`ifdef ALU_SEQ_FLAGS_EN
    logic           rsp_zero;
    logic           rsp_neg;
`endif

    assign load  = (state == IDLE) && bus.cmd_valid && cmd_ready;
    assign go_hi = (state == LO) && (lat_cnt == '0) && wide_q;

    alu_seq_latch #(.W(W)) u_latch (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .go_hi   (go_hi),
        .a_in    (bus.cmd_a),
        .b_in    (bus.cmd_b),
        .s_in    (bus.cmd_s),
        .m_in    (bus.cmd_m),
        .wide_in (bus.cmd_wide),
        .alu_a   (bus.alu_a),
        .alu_b   (bus.alu_b),
        .s       (s_q),
        .m       (m_q),
        .wide    (wide_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_f     <= '0;
            rsp_carry <= 1'b0;
            alu_cin_n <= 1'b1;
            lat_cnt   <= '0;
            res       <= '0;
            c_n       <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        cmd_ready <= 1'b0;
                        alu_cin_n <= bus.cmd_cin_n;
                        lat_cnt   <= LAT_LOAD;
                        state     <= LO;
                    end
                end
                LO: begin
                    if (lat_cnt == '0) begin
                        res[W-1:0] <= bus.alu_f;
                        c_n        <= bus.alu_cout_n;
                        if (wide_q) begin
                            // Active-low carry-out feeds the active-low carry-in unchanged.
                            alu_cin_n <= m_q ? 1'b1 : bus.alu_cout_n;
                            lat_cnt   <= LAT_LOAD;
                            state     <= HI;
                        end else begin
                            res[2*W-1:W] <= '0;
                            state        <= RESP;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                HI: begin
                    if (lat_cnt == '0) begin
                        res[2*W-1:W] <= bus.alu_f;
                        c_n          <= bus.alu_cout_n;
                        state        <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    // First RESP cycle publishes the result; later cycles wait for the consumer.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_f     <= res;
                        rsp_carry <= ~c_n & ~m_q;
`ifdef ALU_SEQ_FLAGS_EN
                        rsp_zero  <= wide_q ? (res == '0) : (res[W-1:0] == '0);
                        rsp_neg   <= wide_q ? res[2*W-1] : res[W-1];
`endif
                    end else if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_f     = rsp_f;
    assign bus.rsp_carry = rsp_carry;
    assign bus.alu_s     = s_q;
    assign bus.alu_m     = m_q;
    assign bus.alu_cin_n = alu_cin_n;
`ifdef ALU_SEQ_FLAGS_EN
    assign bus.rsp_zero  = rsp_zero;
    assign bus.rsp_neg   = rsp_neg;
`endif

endmodule

// File: tb/tb_alu16_seq_driver.sv
// Directed bench for alu16_seq_driver with a behavioural ALU_16bit model;
// flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu16_seq_driver;
    import alu_seq_pkg::*;

    localparam int unsigned W   = ALU_W;
    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu16_seq_driver_if #(.W(W)) bus ();

    alu16_seq_driver #(.ALU_LAT(LAT), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 74181-style ALU slice; logic mode drives cout_n low so an unmasked carry would show.
    logic [W:0] sum;
    always_comb begin
        sum            = '0;
        bus.alu_f      = '0;
        bus.alu_cout_n = 1'b1;
        if (bus.alu_m) begin
            case (bus.alu_s)
                S_AND:   bus.alu_f = bus.alu_a & bus.alu_b;
                S_XOR:   bus.alu_f = bus.alu_a ^ bus.alu_b;
                default: bus.alu_f = bus.alu_a;
            endcase
            bus.alu_cout_n = 1'b0;
        end else begin
            case (bus.alu_s)
                S_ADD:   sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{W{1'b0}}, ~bus.alu_cin_n};
                S_SUB:   sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{W{1'b0}}, ~bus.alu_cin_n};
                default: sum = {1'b0, bus.alu_a} + {{W{1'b0}}, ~bus.alu_cin_n};
            endcase
            bus.alu_f      = sum[W-1:0];
            bus.alu_cout_n = ~sum[W];
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cin_n;
        logic        wide;
        logic [31:0] f;
        logic        c;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[12];

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds cmd_valid until an accepting edge; returns with cmd_valid still high.
    task automatic wait_accept(output logic got);
        logic rdy;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            rdy = bus.cmd_ready;
            tick();
            if (rdy) got = 1'b1;
        end
    endtask

    task automatic wait_rsp(output logic got, output int unsigned cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            cyc++;
            if (bus.rsp_valid) got = 1'b1;
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_a     = v.a;
        bus.cmd_b     = v.b;
        bus.cmd_s     = v.s;
        bus.cmd_m     = v.m;
        bus.cmd_cin_n = v.cin_n;
        bus.cmd_wide  = v.wide;
        bus.cmd_valid = 1'b1;
    endtask

    initial begin
        logic got;
        logic seen;
        int unsigned cyc;
        int unsigned exp_lat;
        logic [31:0] held_f;

        vecs[0]  = '{32'h0000_0003, 32'h0000_000B, S_ADD, 1'b0, 1'b1, 1'b0, 32'h0000_000E, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0009, 32'h0000_0003, S_AND, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0005, 32'h0000_0003, S_SUB, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'hABCD_8000, 32'h1234_0000, S_ADD, 1'b0, 1'b1, 1'b0, 32'h0000_8000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, S_ADD, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'hF0F0_1234, 32'h0FF0_1234, S_XOR, 1'b1, 1'b0, 1'b1, 32'hFF00_0000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h0001_0000, 32'h0000_0001, S_SUB, 1'b0, 1'b0, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h0000_0003, 32'h0000_0005, S_SUB, 1'b0, 1'b0, 1'b0, 32'h0000_FFFE, 1'b0, 1'b0, 1'b1};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_s     = '0;
        bus.cmd_m     = 1'b0;
        bus.cmd_cin_n = 1'b1;
        bus.cmd_wide  = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();

        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_f",     bus.rsp_f,          32'd0);
        chk("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
        chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
        chk("rst_alu_s",     32'(bus.alu_s),     32'd0);
        chk("rst_alu_cin_n", 32'(bus.alu_cin_n), 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rst_flags", 32'({bus.rsp_zero, bus.rsp_neg}), 32'd0);
`endif
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            drive_cmd(vecs[i]);
            wait_accept(got);
            chk($sformatf("vec%0d_accept", i), 32'(got), 32'd1);
            bus.cmd_valid = 1'b0;
            wait_rsp(got, cyc);
            exp_lat = vecs[i].wide ? 2 * LAT + 1 : LAT + 1;
            chk($sformatf("vec%0d_latency", i), cyc, exp_lat);
            chk($sformatf("vec%0d_f", i), bus.rsp_f, vecs[i].f);
            chk($sformatf("vec%0d_carry", i), 32'(bus.rsp_carry), 32'(vecs[i].c));
`ifdef ALU_SEQ_FLAGS_EN
            chk($sformatf("vec%0d_zero", i), 32'(bus.rsp_zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d_neg", i),  32'(bus.rsp_neg),  32'(vecs[i].n));
`endif
        end
        tick();

        // Wide logic op: low pass uses cmd_cin_n, high pass forces cin_n high.
        drive_cmd('{32'h00F0_0009, 32'h00FF_0003, S_AND, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0});
        wait_accept(got);
        bus.cmd_valid = 1'b0;
        chk("wl_lo_cin_n", 32'(bus.alu_cin_n), 32'd0);
        chk("wl_lo_a",     32'(bus.alu_a),     32'h0009);
        chk("wl_lo_sm",    32'({bus.alu_s, bus.alu_m}), 32'h17);
        for (int i = 0; i < LAT; i++) tick();
        chk("wl_hi_cin_n", 32'(bus.alu_cin_n), 32'd1);
        chk("wl_hi_b",     32'(bus.alu_b),     32'h00FF);
        wait_rsp(got, cyc);
        chk("wl_rsp", 32'(got), 32'd1);
        chk("wl_f",     bus.rsp_f,          32'h00F0_0001);
        chk("wl_carry", 32'(bus.rsp_carry), 32'd0);
        tick();

        // Backpressure with a second command waiting.
        bus.rsp_ready = 1'b0;
        drive_cmd('{32'h0000_0010, 32'h0000_0020, S_ADD, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        wait_accept(got);
        chk("bp_accept1", 32'(got), 32'd1);
        drive_cmd('{32'h0000_0001, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        wait_rsp(got, cyc);
        chk("bp_rsp1", 32'(got), 32'd1);
        held_f = 32'h0000_0030;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_valid_%0d", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp_f_%0d", k),     bus.rsp_f,          held_f);
            chk($sformatf("bp_ready_%0d", k), 32'(bus.cmd_ready), 32'd0);
            if (k < 3) tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_hs_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        chk("bp_accept2", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;
        wait_rsp(got, cyc);
        chk("bp_lat2", cyc, LAT + 1);
        chk("bp_f2",   bus.rsp_f, 32'h0000_0002);
        tick();

        // Reset during the high pass of a chained add whose low pass carries.
        drive_cmd('{32'h0001_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0});
        wait_accept(got);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        chk("mr_hi_cin_n", 32'(bus.alu_cin_n), 32'd0);
        chk("mr_hi_a",     32'(bus.alu_a),     32'h0001);
        rst = 1'b1;
        tick();
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mr_cin_n",     32'(bus.alu_cin_n), 32'd1);
        chk("mr_alu_a",     32'(bus.alu_a),     32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
